// File: rtl/plantard_sched.sv
// plantard_sched: two-requester round-robin scheduler feeding an external LAT-deep Plantard core, with drain-and-apply modulus reconfiguration
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   cfg_we, cfg_k1/k2/m/q      configuration strobe and values (shadowed until applied)
//   cfg_busy                   configuration change pending or in progress
//   reqN_valid/ready/a/b       requester operand handshake (N = 0, 1)
//   rspN_valid/c               one-cycle result strobe and result per requester
//   core_a/b/k1/k2/m/q         registered operands and active configuration to the core
//   core_c                     core result, valid LAT edges after operands change
module plantard_sched #(
  parameter int LAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_we,
  input  logic [7:0]   cfg_k1,
  input  logic [7:0]   cfg_k2,
  input  logic [7:0]   cfg_m,
  input  logic [63:0]  cfg_q,
  output logic         cfg_busy,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [63:0]  req0_a,
  input  logic [63:0]  req1_a,
  input  logic [127:0] req0_b,
  input  logic [127:0] req1_b,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  output logic [63:0]  rsp0_c,
  output logic [63:0]  rsp1_c,
  output logic [63:0]  core_a,
  output logic [127:0] core_b,
  output logic [7:0]   core_k1,
  output logic [7:0]   core_k2,
  output logic [7:0]   core_m,
  output logic [63:0]  core_q,
  input  logic [63:0]  core_c
);
  localparam int CW = $clog2(LAT + 2);
  typedef enum logic [1:0] {RUN, DRAIN, APPLY} state_t;
  state_t          r_state;
  logic            r_ptr;
  logic            r_pend;
  logic [7:0]      r_sk1, r_sk2, r_sm;
  logic [63:0]     r_sq;
  logic [CW-1:0]   r_cnt;
  logic [LAT:0]    r_vld, r_tag;
  logic            w_run, w_g0, w_g1, w_xfer, w_out, w_apply;
  // A strobe arriving this cycle already blocks the grant, so no new work slips in ahead of the drain.
  assign w_run      = !rst && (r_state == RUN) && !r_pend && !cfg_we;
  // r_ptr high means req1 has priority on a tie (req0 was granted last).
  assign w_g0       = w_run && req0_valid && (!req1_valid || !r_ptr);
  assign w_g1       = w_run && req1_valid && (!req0_valid || r_ptr);
  assign req0_ready = w_g0;
  assign req1_ready = w_g1;
  assign w_xfer     = w_g0 || w_g1;
  assign w_out      = r_vld[LAT];
  // The new configuration is pushed to the core as DRAIN exits, so it is visible throughout APPLY.
  assign w_apply    = (r_state == DRAIN) && (r_cnt == '0);
  assign cfg_busy   = r_pend || (r_state != RUN);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RUN;
      r_ptr      <= 1'b0;
      r_pend     <= 1'b0;
      r_sk1      <= '0;
      r_sk2      <= '0;
      r_sm       <= '0;
      r_sq       <= '0;
      r_cnt      <= '0;
      r_vld      <= '0;
      r_tag      <= '0;
      core_a     <= '0;
      core_b     <= '0;
      core_k1    <= '0;
      core_k2    <= '0;
      core_m     <= '0;
      core_q     <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_c     <= '0;
      rsp1_c     <= '0;
    end else begin
      if (w_xfer) begin
        core_a <= w_g1 ? req1_a : req0_a;
        core_b <= w_g1 ? req1_b : req0_b;
        r_ptr  <= w_g0;
      end
      r_vld      <= {r_vld[LAT-1:0], w_xfer};
      r_tag      <= {r_tag[LAT-1:0], w_g1};
      r_cnt      <= r_cnt + CW'(w_xfer) - CW'(w_out);
      rsp0_valid <= w_out && !r_tag[LAT];
      rsp1_valid <= w_out && r_tag[LAT];
      if (w_out && !r_tag[LAT]) rsp0_c <= core_c;
      if (w_out && r_tag[LAT]) rsp1_c <= core_c;
      if (cfg_we) begin
        r_sk1 <= cfg_k1;
        r_sk2 <= cfg_k2;
        r_sm  <= cfg_m;
        r_sq  <= cfg_q;
      end
      if (w_apply) begin
        core_k1 <= r_sk1;
        core_k2 <= r_sk2;
        core_m  <= r_sm;
        core_q  <= r_sq;
      end
      // A strobe landing on the apply edge keeps pending set, forcing another drain/apply pass.
      r_pend  <= cfg_we || (r_pend && !w_apply);
      r_state <= w_apply ? APPLY : (r_state == APPLY) ? RUN : (r_pend || cfg_we) ? DRAIN : r_state;
    end
  end
endmodule

// File: tb/tb_plantard_sched.sv
// tb_plantard_sched: randomized scoreboard bench for plantard_sched against a behavioural core and scheduler model
module tb_plantard_sched;
  localparam int LAT = 3;
  logic clk = 1'b0, rst = 1'b0, cfg_we = 1'b0;
  logic [7:0] cfg_k1 = '0, cfg_k2 = '0, cfg_m = '0;
  logic [63:0] cfg_q = '0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [63:0] req0_a = '0, req1_a = '0;
  logic [127:0] req0_b = '0, req1_b = '0;
  logic cfg_busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [63:0] rsp0_c, rsp1_c, core_a, core_q, core_c;
  logic [127:0] core_b;
  logic [7:0] core_k1, core_k2, core_m;
  typedef struct packed {logic [7:0] k1; logic [7:0] k2; logic [7:0] m; logic [63:0] q;} cfg_t;
  typedef struct {logic tag; logic [63:0] c; int iss;} ent_t;
  ent_t sb[$];
  ent_t e;
  cfg_t act, shad, nx, cfg_a;
  logic last_g, pend_m, applied;
  int cyc = 0, tests = 0, fails = 0, we_cyc, app_cyc, last_rsp;
  logic [63:0] pipe [LAT];
  plantard_sched #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_k1(cfg_k1), .cfg_k2(cfg_k2), .cfg_m(cfg_m),
    .cfg_q(cfg_q), .cfg_busy(cfg_busy), .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready), .req0_a(req0_a), .req1_a(req1_a),
    .req0_b(req0_b), .req1_b(req1_b), .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_c(rsp0_c), .rsp1_c(rsp1_c), .core_a(core_a), .core_b(core_b), .core_k1(core_k1),
    .core_k2(core_k2), .core_m(core_m), .core_q(core_q), .core_c(core_c)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [63:0] plantard(input logic [63:0] a, input logic [127:0] b, input logic [7:0] k2, input logic [63:0] q);
    logic [191:0] p;
    logic [127:0] t;
    p = {128'b0, a} * {64'b0, b};
    t = {64'b0, p[127:64]} + (128'd1 << k2);
    p = {64'b0, t} * {128'b0, q};
    return p[127:64];
  endfunction
  // Core: plantard on the registered operands, then an LAT-deep delay line.
  always @(posedge clk) begin
    pipe[0] <= plantard(core_a, core_b, core_k2, core_q);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign core_c = pipe[LAT-1];
  task automatic check(input string name, input logic [511:0] av, input logic [511:0] ev);
    tests++;
    if (av !== ev) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, av, ev);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && (rsp0_valid || rsp1_valid)) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: rsp0_valid=%0b rsp1_valid=%0b with nothing outstanding", rsp0_valid, rsp1_valid);
      end else begin
        e = sb.pop_front();
        check("rsp_tag", {rsp1_valid, rsp0_valid}, e.tag ? 2'b10 : 2'b01);
        check("rsp_c", e.tag ? rsp1_c : rsp0_c, e.c);
        check("rsp_latency", cyc - e.iss, LAT + 1);
        last_rsp = cyc;
      end
    end
  end
  task automatic step(input logic v0, input logic v1, input logic we, input logic rnd);
    logic g;
    logic [1:0] er;
    @(negedge clk);
    req0_valid = v0;
    req1_valid = v1;
    if (rnd) begin
      req0_a = {$urandom, $urandom};
      req1_a = {$urandom, $urandom};
      req0_b = {$urandom, $urandom, $urandom, $urandom};
      req1_b = {$urandom, $urandom, $urandom, $urandom};
    end
    cfg_we = we;
    if (we) {cfg_k1, cfg_k2, cfg_m, cfg_q} = nx;
    #1;
    // Config reaches the core one cycle after the last in-flight result; grants resume a cycle later.
    if (pend_m && !applied && sb.size() == 0 && cyc >= we_cyc + 2 && cyc >= last_rsp + 1) begin
      applied = 1'b1;
      app_cyc = cyc;
      act = shad;
    end else if (applied && cyc >= app_cyc + 1) begin
      applied = 1'b0;
      pend_m = 1'b0;
    end
    check("cfg_busy", cfg_busy, pend_m);
    check("core_cfg", {core_k1, core_k2, core_m, core_q}, act);
    g = (v0 && v1) ? !last_g : v1;
    er = (pend_m || we || !(v0 || v1)) ? 2'b00 : (g ? 2'b10 : 2'b01);
    check("ready", {req1_ready, req0_ready}, er);
    if (er != 2'b00) begin
      last_g = g;
      sb.push_back('{g, plantard(g ? req1_a : req0_a, g ? req1_b : req0_b, act.k2, act.q), cyc + 1});
    end
    if (we) begin
      shad = nx;
      pend_m = 1'b1;
      we_cyc = cyc;
    end
  endtask
  function automatic cfg_t rand_cfg();
    return '{8'($urandom), 8'($urandom_range(0, 16)), 8'($urandom), {1'b0, 31'($urandom), 32'($urandom)} | 64'd1};
  endfunction
  task automatic reset_outputs_zero(input string name);
    check(name, {req0_ready, req1_ready, rsp0_valid, rsp1_valid, cfg_busy, rsp0_c, rsp1_c,
                 core_a, core_b, core_k1, core_k2, core_m, core_q}, '0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    last_g = 1'b1; pend_m = 1'b0; applied = 1'b0; act = '0; shad = '0;
    last_rsp = -100; we_cyc = -100; app_cyc = -100;
    #2 rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1 reset_outputs_zero("reset_state");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    // Single request with the reference configuration and operands.
    nx = '{8'd18, 8'd0, 8'd45, 64'd9223336852482686977};
    step(0, 0, 1, 1);
    for (int i = 0; i < 10 && pend_m; i++) step(0, 0, 0, 1);
    req0_a = 64'd1046808672121123921;
    req0_b = 128'd287595557807817422238232685719981542541;
    step(1, 0, 0, 0);
    repeat (6) step(0, 0, 0, 1);
    // Both requesters held: strict alternation.
    repeat (6) step(1, 1, 0, 1);
    repeat (6) step(0, 0, 0, 1);
    // Random traffic, including valids that drop before being granted.
    repeat (200) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1);
    // Reconfigure in the middle of back-to-back traffic.
    repeat (5) step(1, 1, 0, 1);
    nx = rand_cfg();
    step(1, 1, 1, 1);
    repeat (15) step(1, 1, 0, 1);
    // Two strobes two cycles apart while draining: only the second is ever applied.
    repeat (5) step(1, 0, 0, 1);
    nx = rand_cfg();
    cfg_a = nx;
    step(1, 0, 1, 1);
    step(1, 0, 0, 1);
    nx = rand_cfg();
    if (nx == cfg_a) nx.q = nx.q ^ 64'h2;
    step(1, 0, 1, 1);
    repeat (15) step(1, 0, 0, 1);
    repeat (6) step(0, 0, 0, 1);
    // Reset with three results in flight.
    repeat (3) step(1, 1, 0, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 reset_outputs_zero("reset_midflight");
    sb.delete();
    last_g = 1'b1; pend_m = 1'b0; applied = 1'b0; act = '0; shad = '0;
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (10) step(0, 0, 0, 1);
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);
    for (int i = 0; i < 20 && sb.size() != 0; i++) step(0, 0, 0, 1);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
